// File: rtl/hub75_pixel_fetch.sv
// hub75_pixel_fetch: turns each load strobe from matrix_scan into a top/bottom
// frame-buffer read pair and presents the HUB75 colour bits for the active
// brightness bit-plane.
// Optional feature macro: PIXEL_OVERRUN_DETECT_EN. When defined, a load edge that
// arrives mid-fetch sets the sticky overrun flag and restarts the fetch; otherwise
// the late edge is ignored and overrun stays 0.
module hub75_pixel_fetch #(
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [5:0]  column_address,
    input  logic [3:0]  row_address,
    input  logic        clk_pixel_load,
    input  logic [5:0]  brightness_mask,
    output logic [10:0] ram_addr,
    output logic        ram_rd_en,
    input  logic [15:0] ram_data,
    output logic [2:0]  rgb1,
    output logic [2:0]  rgb2,
    output logic        pixel_ready,
    output logic        overrun
);

    localparam int unsigned COL_W  = 6;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned MASK_W = 6;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RGB_W  = 3;
    localparam int unsigned SR_W   = RAM_LATENCY;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_TOP,
        ST_REQ_BOT,
        ST_WAIT,
        ST_PRESENT
    } state_t;

    state_t              state;
    logic                load_q;
    logic                load_edge;
    logic                late_edge;
    logic                start;
    logic [ROW_W-1:0]    row_h;
    logic [COL_W-1:0]    col_h;
    logic [MASK_W-1:0]   mask_h;
    logic [SR_W-1:0]     vld_sr;
    logic [SR_W-1:0]     tag_sr;
    logic [DATA_W-1:0]   top_q;
    logic                top_cap;
    logic                bot_cap;

    // Expand RGB565 to 6-bit channels and reduce each against the bit-plane mask.
    function automatic logic [RGB_W-1:0] plane_bits(input logic [DATA_W-1:0] px,
                                                    input logic [MASK_W-1:0] mask);
        logic [MASK_W-1:0] r6;
        logic [MASK_W-1:0] g6;
        logic [MASK_W-1:0] b6;
        r6 = {px[15:11], px[15]};
        g6 = px[10:5];
        b6 = {px[4:0], px[4]};
        return {|(r6 & mask), |(g6 & mask), |(b6 & mask)};
    endfunction

    assign load_edge = clk_pixel_load & ~load_q;

`ifdef PIXEL_OVERRUN_DETECT_EN
    assign late_edge = load_edge & (state != ST_IDLE);

    // Sticky flag for a load edge that arrived while a fetch was busy.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (late_edge) begin
            overrun <= 1'b1;
        end
    end
`else
    assign late_edge = 1'b0;
    assign overrun   = 1'b0;
`endif

    // A fetch begins on an idle edge or restarts on a late edge.
    assign start = (load_edge & (state == ST_IDLE)) | late_edge;

    // Read data is tagged by half and captured when its valid bit leaves the pipe.
    assign top_cap = vld_sr[SR_W-1] & ~tag_sr[SR_W-1];
    assign bot_cap = vld_sr[SR_W-1] &  tag_sr[SR_W-1];

    // Valid/tag pipeline tracking outstanding reads; flushed on restart.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            vld_sr <= '0;
            tag_sr <= '0;
        end else if (late_edge) begin
            vld_sr <= '0;
            tag_sr <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | SR_W'(ram_rd_en);
            tag_sr <= (tag_sr << 1) | SR_W'(ram_addr[ADDR_W-1]);
        end
    end

    // Fetch sequencer with registered RAM strobe, address and pixel outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            load_q      <= 1'b0;
            ram_addr    <= '0;
            ram_rd_en   <= 1'b0;
            rgb1        <= '0;
            rgb2        <= '0;
            pixel_ready <= 1'b0;
            row_h       <= '0;
            col_h       <= '0;
            mask_h      <= '0;
            top_q       <= '0;
        end else begin
            load_q      <= clk_pixel_load;
            pixel_ready <= 1'b0;
            if (top_cap) begin
                top_q <= ram_data;
            end
            if (start) begin
                row_h     <= row_address;
                col_h     <= column_address;
                mask_h    <= brightness_mask;
                state     <= ST_REQ_TOP;
                ram_rd_en <= 1'b1;
                ram_addr  <= {1'b0, row_address, column_address};
            end else begin
                case (state)
                    ST_IDLE: begin
                        ram_rd_en <= 1'b0;
                    end
                    ST_REQ_TOP: begin
                        state     <= ST_REQ_BOT;
                        ram_rd_en <= 1'b1;
                        ram_addr  <= {1'b1, row_h, col_h};
                    end
                    ST_REQ_BOT: begin
                        state     <= ST_WAIT;
                        ram_rd_en <= 1'b0;
                    end
                    ST_WAIT: begin
                        if (bot_cap) begin
                            state       <= ST_PRESENT;
                            pixel_ready <= 1'b1;
                            rgb1        <= plane_bits(top_q, mask_h);
                            rgb2        <= plane_bits(ram_data, mask_h);
                        end
                    end
                    ST_PRESENT: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        ram_rd_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
